// File: rtl/jtag_dbg_bridge_pkg.sv
// Shared types and constants for the JTAG debug bridge (core clock domain).
package jtag_dbg_bridge_pkg;

    // Bridge FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REQ    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;

    // Width of the grant-wait counter; covers TIMEOUT_CYCLES up to 65535.
    localparam int TmoW = 16;

endpackage

// File: rtl/jtag_dbg_bridge_if.sv
// System bus master port of the debug bridge: single-beat req/gnt handshake.
interface jtag_dbg_bridge_if;

    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        m_gnt_i;

    // Bridge side drives the request, the bus fabric answers with grant/data.
    modport master (
        output m_req_o, m_we_o, m_addr_o, m_wdata_o,
        input  m_rdata_i, m_gnt_i
    );

    modport slave (
        input  m_req_o, m_we_o, m_addr_o, m_wdata_o,
        output m_rdata_i, m_gnt_i
    );

endinterface

// File: rtl/jtag_dbg_bridge_pulse_stretch.sv
// Rising-edge detect on a synchronized request level, stretched into a
// fixed-width active-high pulse. A new rise during a pulse restarts it.
module dbg_pulse_stretch #(
    parameter int RST_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    localparam int CntW = $clog2(RST_HOLD + 1);

    logic            level_q;
    logic [CntW-1:0] hold_cnt;
    logic            rise;

    assign rise  = level & ~level_q;
    assign pulse = (hold_cnt != '0);

    // Edge history resets high so a level already asserted at reset release is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q  <= 1'b1;
            hold_cnt <= '0;
        end else begin
            level_q <= level;
            if (rise)
                hold_cnt <= CntW'(RST_HOLD);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - CntW'(1);
        end
    end

endmodule

// File: rtl/jtag_dbg_bridge.sv
// Core-side consumer of the synchronized JTAG debug outputs: turns each op_req
// rising edge into one system-bus access, returns read data, stalls the core
// while busy and stretches reset requests into a core reset pulse.
import jtag_dbg_bridge_pkg::*;

module jtag_dbg_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter int          RST_HOLD       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_req_i,
    input  logic                     mem_we_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_wdata_i,
    input  logic                     halt_req_i,
    input  logic                     reset_req_i,
    jtag_dbg_bridge_if.master        bus,
    output logic [31:0]              rdata_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     halt_o,
    output logic                     reset_o
);

    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            op_req_q;
    logic            op_rise;
    logic [TmoW-1:0] tmo_cnt;

    assign op_rise = op_req_i & ~op_req_q;

    // Bridge FSM; every bus/DM output is a register written here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_req_q      <= 1'b1;
            tmo_cnt       <= '0;
            bus.m_req_o   <= 1'b0;
            bus.m_we_o    <= WriteDisable;
            bus.m_addr_o  <= ZeroWord;
            bus.m_wdata_o <= ZeroWord;
            rdata_o       <= ZeroWord;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            halt_o        <= 1'b0;
        end else begin
            // Edge history tracks the input in all states, so a rise seen
            // while busy is consumed and never starts a second access.
            op_req_q <= op_req_i;
            halt_o   <= halt_req_i | (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (op_rise) begin
                        err_o <= 1'b0;
                        state <= ST_SETTLE;
                    end
                end

                // Multi-bit operands crossed via plain double flops; give them
                // one extra cycle before sampling so all bits agree.
                ST_SETTLE: begin
                    bus.m_we_o    <= mem_we_i;
                    bus.m_addr_o  <= mem_addr_i;
                    bus.m_wdata_o <= mem_wdata_i;
                    bus.m_req_o   <= 1'b1;
                    tmo_cnt       <= '0;
                    state         <= ST_REQ;
                end

                ST_REQ: begin
                    if (bus.m_gnt_i) begin
                        if (!bus.m_we_o)
                            rdata_o <= bus.m_rdata_i;
                        bus.m_req_o <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= ST_DONE;
                    end else if (tmo_cnt == TmoLast) begin
                        if (!bus.m_we_o)
                            rdata_o <= ERR_DATA;
                        err_o       <= 1'b1;
                        bus.m_req_o <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
                end

                ST_DONE: begin
                    if (!op_req_i) begin
                        done_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Core reset pulse runs independently of the bus FSM.
    dbg_pulse_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_stretch (
        .clk   (clk),
        .rst_n (rst_n),
        .level (reset_req_i),
        .pulse (reset_o)
    );

endmodule

// File: tb/tb_jtag_dbg_bridge.sv
// Self-checking bench for jtag_dbg_bridge: directed scenarios plus randomized
// ops and reset-request patterns against a behavioural model.
module tb_jtag_dbg_bridge;

    localparam int          TMO  = 8;
    localparam int          HOLD = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        halt_req_i = 1'b0;
    logic        reset_req_i = 1'b0;
    logic [31:0] rdata_o;
    logic        done_o, err_o, halt_o, reset_o;

    jtag_dbg_bridge_if bus();

    int total = 0;
    int bad   = 0;

    // Model state: last value the DM should see on rdata_o.
    logic [31:0] exp_rdata = '0;

    typedef struct {
        int          first_req;
        int          req_cyc;
        int          beats;
        int          done_cyc;
        int          hold_bad;
        int          halt_bad;
        logic        err_start;
        logic        err_end;
        logic        done_after;
        logic [31:0] rdata;
    } op_res_t;

    always #5 clk = ~clk;

    jtag_dbg_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (ERRD),
        .RST_HOLD       (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_req_i    (op_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .halt_req_i  (halt_req_i),
        .reset_req_i (reset_req_i),
        .bus         (bus),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .halt_o      (halt_o),
        .reset_o     (reset_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one op and plays a bus slave that grants after gdel waiting cycles.
    // Operands are junk until SETTLE, valid for the latch edge, junk again after.
    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int gdel, output op_res_t r);
        r.first_req = -1; r.req_cyc = 0; r.beats = 0; r.done_cyc = -1;
        r.hold_bad = 0; r.halt_bad = 0; r.err_start = 1'b0;
        op_req_i = 1'b0;
        tick;
        op_req_i = 1'b1;
        mem_we_i = ~we; mem_addr_i = $urandom; mem_wdata_i = $urandom;
        for (int c = 1; c < 200; c++) begin
            tick;
            bus.m_gnt_i = 1'b0;
            bus.m_rdata_i = $urandom;
            if (c == 1) begin
                r.err_start = err_o;
                mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
            end else begin
                mem_we_i = $urandom_range(0, 1); mem_addr_i = $urandom; mem_wdata_i = $urandom;
            end
            if (bus.m_req_o) begin
                if (r.first_req < 0) r.first_req = c;
                r.req_cyc++;
                if (halt_o !== 1'b1) r.halt_bad++;
                if (bus.m_we_o !== we || bus.m_addr_o !== addr || bus.m_wdata_o !== wdata)
                    r.hold_bad++;
                if (r.req_cyc - 1 == gdel) begin
                    bus.m_gnt_i = 1'b1;
                    bus.m_rdata_i = rd;
                    r.beats++;
                end
            end
            if (done_o === 1'b1 && r.done_cyc < 0) r.done_cyc = c;
            if (r.done_cyc > 0 && c >= r.done_cyc + 2) break;
        end
        bus.m_gnt_i = 1'b0;
        r.rdata = rdata_o;
        r.err_end = err_o;
        op_req_i = 1'b0;
        tick;
        tick;
        r.done_after = done_o;
    endtask

    task automatic test_reset;
        int req_seen = 0, rst_seen = 0, done_seen = 0;
        rst_n = 1'b0; op_req_i = 1'b1; reset_req_i = 1'b1; halt_req_i = 1'b0;
        bus.m_gnt_i = 1'b0; bus.m_rdata_i = '0;
        repeat (3) tick;
        total++;
        if ({bus.m_req_o, bus.m_we_o, done_o, err_o, halt_o, reset_o} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000",
                            {bus.m_req_o, bus.m_we_o, done_o, err_o, halt_o, reset_o});
        end
        total++;
        if (rdata_o !== 32'h0 || bus.m_addr_o !== 32'h0 || bus.m_wdata_o !== 32'h0) begin
            bad++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h want=0", rdata_o,
                            bus.m_addr_o, bus.m_wdata_o);
        end
        // Levels already high at release must not fire.
        rst_n = 1'b1;
        repeat (6) begin
            tick;
            if (bus.m_req_o) req_seen++;
            if (reset_o) rst_seen++;
            if (done_o) done_seen++;
        end
        total++;
        if (req_seen != 0 || rst_seen != 0 || done_seen != 0) begin
            bad++; $display("FAIL reset_release_levels req=%0d rst=%0d done=%0d want=0", req_seen,
                            rst_seen, done_seen);
        end
        op_req_i = 1'b0; reset_req_i = 1'b0;
        tick;
    endtask

    task automatic test_halt;
        logic h;
        int errs = 0;
        for (int i = 0; i < 30; i++) begin
            h = 1'($urandom_range(0, 1));
            halt_req_i = h;
            tick;
            if (halt_o !== h) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL halt_idle mismatches=%0d want=0", errs);
        end
        halt_req_i = 1'b0;
        tick;
    endtask

    task automatic test_read_immediate;
        op_res_t r;
        run_op(1'b0, 32'h1000_0004, 32'h0, 32'h1234_5678, 0, r);
        exp_rdata = 32'h1234_5678;
        total++;
        if (r.first_req != 2 || r.req_cyc != 1) begin
            bad++; $display("FAIL read_imm_req first=%0d cycles=%0d want first=2 cycles=1",
                            r.first_req, r.req_cyc);
        end
        total++;
        if (r.done_cyc != 3 || r.rdata !== exp_rdata) begin
            bad++; $display("FAIL read_imm_done done_at=%0d rdata=%h want done_at=3 rdata=%h",
                            r.done_cyc, r.rdata, exp_rdata);
        end
        total++;
        if (r.halt_bad != 0 || r.hold_bad != 0) begin
            bad++; $display("FAIL read_imm_halt_bus halt_bad=%0d hold_bad=%0d want 0/0",
                            r.halt_bad, r.hold_bad);
        end
    endtask

    task automatic test_write_delayed;
        op_res_t r;
        run_op(1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 32'h5555_0000, 5, r);
        total++;
        if (r.req_cyc != 6 || r.beats != 1 || r.hold_bad != 0) begin
            bad++; $display("FAIL write_delay req=%0d beats=%0d hold_bad=%0d want 6/1/0",
                            r.req_cyc, r.beats, r.hold_bad);
        end
        total++;
        if (r.rdata !== exp_rdata || r.err_end !== 1'b0) begin
            bad++; $display("FAIL write_delay_rdata rdata=%h err=%b want %h/0", r.rdata,
                            r.err_end, exp_rdata);
        end
    endtask

    task automatic test_timeout;
        op_res_t r;
        run_op(1'b0, 32'h3000_0010, 32'h0, 32'h0BAD_0BAD, 1000, r);
        exp_rdata = ERRD;
        total++;
        if (r.req_cyc != TMO || r.beats != 0 || r.done_cyc != 2 + TMO) begin
            bad++; $display("FAIL timeout_len req=%0d beats=%0d done_at=%0d want %0d/0/%0d",
                            r.req_cyc, r.beats, r.done_cyc, TMO, 2 + TMO);
        end
        total++;
        if (r.err_end !== 1'b1 || r.rdata !== ERRD) begin
            bad++; $display("FAIL timeout_err err=%b rdata=%h want 1/%h", r.err_end, r.rdata, ERRD);
        end
        // Next op must clear the sticky flag as soon as it is accepted.
        run_op(1'b0, 32'h3000_0014, 32'h0, 32'hCAFE_F00D, 1, r);
        exp_rdata = 32'hCAFE_F00D;
        total++;
        if (r.err_start !== 1'b0 || r.err_end !== 1'b0 || r.rdata !== exp_rdata) begin
            bad++; $display("FAIL timeout_clear err_start=%b err_end=%b rdata=%h want 0/0/%h",
                            r.err_start, r.err_end, r.rdata, exp_rdata);
        end
    endtask

    task automatic test_hold_high;
        int req = 0;
        op_req_i = 1'b0;
        tick;
        mem_we_i = 1'b1; mem_addr_i = 32'h4000_0000; mem_wdata_i = 32'h0000_1111;
        op_req_i = 1'b1;
        for (int c = 1; c < 40; c++) begin
            tick;
            bus.m_gnt_i = 1'b0;
            if (bus.m_req_o) begin
                req++;
                if (req == 2) op_req_i = 1'b0;
                if (req == 3) op_req_i = 1'b1;
                if (req == 5) bus.m_gnt_i = 1'b1;
            end
        end
        bus.m_gnt_i = 1'b0;
        total++;
        if (req != 5 || done_o !== 1'b1) begin
            bad++; $display("FAIL hold_high req_cycles=%0d done=%b want 5/1", req, done_o);
        end
        op_req_i = 1'b0;
        tick;
        tick;
        total++;
        if (done_o !== 1'b0 || rdata_o !== exp_rdata) begin
            bad++; $display("FAIL hold_high_exit done=%b rdata=%h want 0/%h", done_o, rdata_o,
                            exp_rdata);
        end
    endtask

    task automatic test_random_ops;
        op_res_t r;
        logic we;
        logic [31:0] addr, wdata, rd;
        int gdel, exp_req, errs;
        logic exp_err;
        for (int i = 0; i < 12; i++) begin
            we = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; rd = $urandom;
            gdel = $urandom_range(0, TMO + 3);
            run_op(we, addr, wdata, rd, gdel, r);
            exp_err = (gdel >= TMO);
            exp_req = exp_err ? TMO : gdel + 1;
            if (!we) exp_rdata = exp_err ? ERRD : rd;
            errs = 0;
            if (r.first_req != 2) errs++;
            if (r.req_cyc != exp_req) errs++;
            if (r.beats != (exp_err ? 0 : 1)) errs++;
            if (r.done_cyc != 2 + exp_req) errs++;
            if (r.hold_bad != 0 || r.halt_bad != 0) errs++;
            if (r.err_start !== 1'b0 || r.err_end !== exp_err) errs++;
            if (r.done_after !== 1'b0) errs++;
            total++;
            if (errs != 0 || r.rdata !== exp_rdata) begin
                bad++;
                $display("FAIL rand_op%0d we=%b gdel=%0d req=%0d/%0d done_at=%0d/%0d err=%b/%b rdata=%h/%h other=%0d",
                         i, we, gdel, r.req_cyc, exp_req, r.done_cyc, 2 + exp_req, r.err_end,
                         exp_err, r.rdata, exp_rdata, errs);
            end
        end
    endtask

    // reset_o must be high at cycle c iff some rise e satisfies e <= c < e+HOLD.
    task automatic test_reset_pulse;
        int rises[$];
        logic prev, lvl, expv;
        int high_first40 = 0;
        reset_req_i = 1'b0;
        repeat (HOLD + 2) tick;
        prev = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (c < 40) lvl = (c < 8) || (c >= 10);
            else        lvl = ($urandom_range(0, 5) == 0) ? ~prev : prev;
            reset_req_i = lvl;
            if (lvl && !prev) rises.push_back(c);
            prev = lvl;
            tick;
            expv = 1'b0;
            foreach (rises[k]) if (c >= rises[k] && c < rises[k] + HOLD) expv = 1'b1;
            if (c < 40 && reset_o === 1'b1) high_first40++;
            total++;
            if (reset_o !== expv) begin
                bad++; $display("FAIL rst_pulse c=%0d got=%b want=%b", c, reset_o, expv);
            end
        end
        total++;
        if (high_first40 != 26) begin
            bad++; $display("FAIL rst_pulse_extend high_cycles=%0d want 26", high_first40);
        end
        reset_req_i = 1'b0;
        repeat (HOLD + 2) tick;
    endtask

    task automatic test_rst_mid;
        op_res_t r;
        int req_after = 0;
        op_req_i = 1'b0;
        tick;
        mem_we_i = 1'b1; mem_addr_i = 32'h5000_0000; mem_wdata_i = 32'h7777_7777;
        op_req_i = 1'b1;
        repeat (3) tick;
        total++;
        if (bus.m_req_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre m_req=%b want 1", bus.m_req_o);
        end
        rst_n = 1'b0;
        tick;
        exp_rdata = 32'h0;
        total++;
        if (bus.m_req_o !== 1'b0 || done_o !== 1'b0 || halt_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid_drop m_req=%b done=%b halt=%b want 0/0/0", bus.m_req_o,
                            done_o, halt_o);
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick;
            if (bus.m_req_o) req_after++;
        end
        total++;
        if (req_after != 0) begin
            bad++; $display("FAIL rst_mid_no_retry req_cycles=%0d want 0", req_after);
        end
        // A genuine toggle afterwards starts a normal access.
        run_op(1'b0, 32'h5000_0008, 32'h0, 32'h0123_4567, 2, r);
        exp_rdata = 32'h0123_4567;
        total++;
        if (r.req_cyc != 3 || r.beats != 1 || r.rdata !== exp_rdata) begin
            bad++; $display("FAIL rst_mid_after req=%0d beats=%0d rdata=%h want 3/1/%h",
                            r.req_cyc, r.beats, r.rdata, exp_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_halt;
        test_read_immediate;
        test_write_delayed;
        test_timeout;
        test_hold_high;
        test_random_ops;
        test_reset_pulse;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
